// File: rtl/and1_sync.sv
// Registered bitwise AND with valid qualification and result flags.
// Free-running pipeline of G_LATENCY stages; flags land with the final stage.
module and1_sync #(
    parameter int G_WIDTH   = 8,
    parameter int G_LATENCY = 1,
    localparam int PW       = $clog2(G_WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [G_WIDTH-1:0] a,
    input  logic [G_WIDTH-1:0] b,
    output logic               out_valid,
    output logic [G_WIDTH-1:0] c,
    output logic               c_zero,
    output logic               c_ones,
    output logic [PW-1:0]      c_popcnt
);

    logic [G_WIDTH-1:0] stg_q [G_LATENCY];
    logic [G_WIDTH-1:0] stg_d [G_LATENCY];
    logic               vld_q [G_LATENCY];
    logic               vld_d [G_LATENCY];
    logic [PW-1:0]      cnt;
    logic               zero_q;
    logic               ones_q;
    logic [PW-1:0]      cnt_q;

    always_comb begin
        stg_d[0] = a & b;
        vld_d[0] = in_valid;
        for (int i = 1; i < G_LATENCY; i++) begin
            stg_d[i] = stg_q[i-1];
            vld_d[i] = vld_q[i-1];
        end
    end

    // Flags derive from the word entering the last stage so they stay coherent with c.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < G_WIDTH; i++) begin
            cnt = cnt + PW'(stg_d[G_LATENCY-1][i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < G_LATENCY; i++) begin
                stg_q[i] <= '0;
                vld_q[i] <= 1'b0;
            end
            zero_q <= 1'b1;
            ones_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < G_LATENCY; i++) begin
                stg_q[i] <= stg_d[i];
                vld_q[i] <= vld_d[i];
            end
            zero_q <= (stg_d[G_LATENCY-1] == '0);
            ones_q <= (stg_d[G_LATENCY-1] == '1);
            cnt_q  <= cnt;
        end
    end

    assign out_valid = vld_q[G_LATENCY-1];
    assign c         = stg_q[G_LATENCY-1];
    assign c_zero    = zero_q;
    assign c_ones    = ones_q;
    assign c_popcnt  = cnt_q;

endmodule

// File: tb/tb_and1_sync.sv
// Randomized bench for and1_sync at latency 1 and 3, checked against
// a per-edge history model of the input stream.
module tb_and1_sync;

    localparam int W  = 8;
    localparam int PW = $clog2(W + 1);
    localparam int N  = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic          ov1, z1, o1;
    logic [W-1:0]  c1;
    logic [PW-1:0] p1;
    logic          ov3, z3, o3;
    logic [W-1:0]  c3;
    logic [PW-1:0] p3;

    and1_sync #(.G_WIDTH(W), .G_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ov1), .c(c1), .c_zero(z1), .c_ones(o1), .c_popcnt(p1)
    );

    and1_sync #(.G_WIDTH(W), .G_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ov3), .c(c3), .c_zero(z3), .c_ones(o3), .c_popcnt(p3)
    );

    logic         h_r [N];
    logic         h_v [N];
    logic [W-1:0] h_a [N];
    logic [W-1:0] h_b [N];
    int n = 0;
    int checks = 0;
    int passes = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n - 1);
    endtask

    // Output after edge m carries the sample of edge m-lat+1, unless any
    // reset edge (or pre-history) lies in that window.
    task automatic model(input int lat, input int m,
                         output logic v, output logic [W-1:0] r);
        int s;
        logic clr;
        s = m - lat + 1;
        clr = (s < 0);
        for (int k = (s < 0 ? 0 : s); k <= m; k++)
            if (!h_r[k]) clr = 1'b1;
        if (clr) begin
            v = 1'b0;
            r = '0;
        end else begin
            v = h_v[s];
            r = h_a[s] & h_b[s];
        end
    endtask

    task automatic cmp(string tag, int lat, logic ov, logic [W-1:0] cv,
                       logic z, logic o, logic [PW-1:0] p);
        logic         ev;
        logic [W-1:0] ec;
        model(lat, n - 1, ev, ec);
        check({tag, ".valid"}, 32'(ov), 32'(ev));
        check({tag, ".c"},     32'(cv), 32'(ec));
        check({tag, ".zero"},  32'(z),  32'(ec == 0));
        check({tag, ".ones"},  32'(o),  32'(ec == 8'hFF));
        check({tag, ".pop"},   32'(p),  32'($countones(ec)));
    endtask

    task automatic step(input logic r, input logic v,
                        input logic [W-1:0] x, input logic [W-1:0] y);
        rst_n    = r;
        in_valid = v;
        a        = x;
        b        = y;
        @(posedge clk);
        h_r[n] = r;
        h_v[n] = v;
        h_a[n] = x;
        h_b[n] = y;
        n++;
        @(negedge clk);
        cmp("L1", 1, ov1, c1, z1, o1, p1);
        cmp("L3", 3, ov3, c3, z3, o3, p3);
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;

        // reset held with valid data present
        repeat (3) step(1'b0, 1'b1, 8'hFF, 8'hFF);
        step(1'b1, 1'b0, 8'h00, 8'h00);

        // basic and extremes
        step(1'b1, 1'b1, 8'hA5, 8'h3C);
        step(1'b1, 1'b1, 8'hFF, 8'hFF);
        step(1'b1, 1'b1, 8'hFF, 8'h00);
        repeat (3) step(1'b1, 1'b0, rnd(), rnd());

        // back-to-back streaming
        repeat (50) step(1'b1, 1'b1, rnd(), rnd());

        // bubble pattern
        step(1'b1, 1'b1, rnd(), rnd());
        step(1'b1, 1'b0, rnd(), rnd());
        step(1'b1, 1'b1, rnd(), rnd());
        step(1'b1, 1'b1, rnd(), rnd());
        repeat (4) step(1'b1, 1'b0, rnd(), rnd());

        // mid-flight reset
        repeat (3) step(1'b1, 1'b1, rnd(), rnd());
        step(1'b0, 1'b1, rnd(), rnd());
        step(1'b1, 1'b1, 8'hC3, 8'h5A);
        repeat (4) step(1'b1, 1'b0, rnd(), rnd());

        // mixed traffic with sporadic resets
        repeat (200)
            step(($urandom_range(0, 15) != 0), 1'($urandom), rnd(), rnd());
        repeat (4) step(1'b1, 1'b0, rnd(), rnd());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
